// File: rtl/verdict_collector_if.sv
// verdict_collector_if: valid/ready byte link from the collector to the host side
interface verdict_collector_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/verdict_collector.sv
// verdict_collector: buffers monitor verdict records in a FIFO and streams them as 11-byte frames
module verdict_collector #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     output_lt,
  input  logic                     output_gt,
  input  logic                     output_neq,
  input  logic                     output_not_a,
  input  logic                     output_a_impl_b,
  input  logic [7:0]               output_time_stream,
  input  logic                     output_lt_aktv,
  input  logic                     output_gt_aktv,
  input  logic                     output_neq_aktv,
  input  logic                     output_not_a_aktv,
  input  logic                     output_a_impl_b_aktv,
  input  logic                     output_time_stream_aktv,
  input  logic [63:0]              hlc_clock_cnt,
  verdict_collector_if.master      tx,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 88;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t          state, state_nx;
  logic [5:0]      mask;
  logic [4:0]      bools;
  logic [7:0]      ts;
  logic [RW-1:0]   rec;
  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [RW-1:0]   shift;
  logic [3:0]      idx;
  logic            capture, full, push, drop, pop, hs, last;
  assign mask    = {output_time_stream_aktv, output_a_impl_b_aktv, output_not_a_aktv,
                    output_neq_aktv, output_gt_aktv, output_lt_aktv};
  assign bools   = {output_a_impl_b, output_not_a, output_neq, output_gt, output_lt} & mask[4:0];
  assign ts      = mask[5] ? output_time_stream : 8'h00;
  assign rec     = {2'b00, mask, 3'b000, bools, ts, hlc_clock_cnt};
  assign capture = en && mask != 6'd0;
  // fullness uses the start-of-cycle count, so a same-cycle pop never rescues a capture
  assign full    = fifo_count == CNT_FULL;
  assign push    = capture && !full;
  assign drop    = capture && full;
  assign hs      = tx.tx_valid && tx.tx_ready;
  assign last    = idx == 4'd10;
  assign tx.tx_data = tx.tx_valid ? shift[RW-1 -: 8] : 8'h00;
  // serializer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // serializer next state: pop in IDLE, send bytes until the eleventh handshake
  always_comb begin
    state_nx    = state;
    pop         = 1'b0;
    tx.tx_valid = 1'b0;
    if (state == IDLE) begin
      pop      = fifo_count != '0;
      state_nx = pop ? SEND : IDLE;
    end else begin
      tx.tx_valid = 1'b1;
      state_nx    = (tx.tx_ready && last) ? IDLE : SEND;
    end
  end
  // record storage, written only for accepted captures
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rec;
  end
  // shift register loads the head record and advances one byte per handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      idx   <= 4'd0;
    end else if (pop) begin
      shift <= mem[rd_ptr];
      idx   <= 4'd0;
    end else if (hs && !last) begin
      shift <= shift << 8;
      idx   <= idx + 4'd1;
    end
  end
  // circular pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // sticky drop accounting, saturating at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_verdict_collector.sv
// tb_verdict_collector: directed and randomized checks of verdict_collector against a record-queue model
module tb_verdict_collector;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [5:0] aktv = '0;
  logic [4:0] bv = '0;
  logic [7:0] ts = '0;
  logic [63:0] hlc = '0;
  logic [$clog2(DEPTH):0] fifo_count;
  logic overflow;
  logic [7:0] drop_count;
  int n_chk = 0;
  int n_err = 0;
  int hs_cnt = 0;
  logic m_ovf = 1'b0;
  int m_drop = 0;
  logic [87:0] mq[$];
  logic [7:0] bq[$];
  logic [7:0] log_q[$];
  logic [7:0] exp1 [11] = '{8'h3D, 8'h05, 8'hFD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34};

  verdict_collector_if tx ();

  always #5 clk = ~clk;

  verdict_collector #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .output_lt(bv[0]), .output_gt(bv[1]), .output_neq(bv[2]),
    .output_not_a(bv[3]), .output_a_impl_b(bv[4]),
    .output_time_stream(ts),
    .output_lt_aktv(aktv[0]), .output_gt_aktv(aktv[1]), .output_neq_aktv(aktv[2]),
    .output_not_a_aktv(aktv[3]), .output_a_impl_b_aktv(aktv[4]),
    .output_time_stream_aktv(aktv[5]),
    .hlc_clock_cnt(hlc), .tx(tx.master),
    .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // a record as its eleven bytes, built straight from the byte layout
  function automatic logic [87:0] mk(logic [5:0] m, logic [4:0] v, logic [7:0] t, logic [63:0] h);
    logic [7:0] b [11];
    logic [87:0] r;
    b[0] = {2'b00, m};
    b[1] = 8'h00;
    for (int i = 0; i < 5; i++) b[1][i] = v[i] & m[i];
    b[2] = m[5] ? t : 8'h00;
    for (int i = 0; i < 8; i++) b[3+i] = h[63-8*i -: 8];
    r = '0;
    for (int i = 0; i < 11; i++) r = {r[79:0], b[i]};
    return r;
  endfunction

  always @(negedge clk) begin : cmp
    logic [87:0] r;
    logic full;
    if (!rst_n) begin
      mq.delete();
      bq.delete();
      m_ovf = 1'b0;
      m_drop = 0;
      chk("rst_tx_valid", tx.tx_valid, 0);
      chk("rst_tx_data", tx.tx_data, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_drop_count", drop_count, 0);
    end else begin
      chk("tx_valid", tx.tx_valid, bq.size() != 0);
      if (bq.size() != 0) chk("tx_data", tx.tx_data, bq[0]);
      chk("fifo_count", fifo_count, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("drop_count", drop_count, m_drop);
      if (tx.tx_valid && tx.tx_ready) begin
        log_q.push_back(tx.tx_data);
        hs_cnt++;
      end
      full = mq.size() == DEPTH;
      if (bq.size() == 0 && mq.size() != 0) begin
        r = mq.pop_front();
        for (int i = 0; i < 11; i++) bq.push_back(r[87-8*i -: 8]);
      end else if (bq.size() != 0 && tx.tx_ready) begin
        void'(bq.pop_front());
      end
      if (en && aktv != 6'd0) begin
        if (full) begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end else begin
          mq.push_back(mk(aktv, bv, ts, hlc));
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(logic e, logic [5:0] a, logic [4:0] v, logic [7:0] t, logic [63:0] h);
    en = e; aktv = a; bv = v; ts = t; hlc = h;
  endtask

  task automatic idle_in();
    drive(1'b0, 6'd0, 5'd0, 8'd0, 64'd0);
  endtask

  task automatic drain(int max);
    int i = 0;
    tx.tx_ready = 1'b1;
    while (i < max && (mq.size() != 0 || bq.size() != 0)) begin
      cyc(1);
      i++;
    end
    cyc(2);
    chk("drain_done", mq.size() + bq.size(), 0);
  endtask

  initial begin
    int hs0;
    int lb;
    tx.tx_ready = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    // single record with ready held high: exact cycle-by-cycle bytes
    tx.tx_ready = 1'b1;
    drive(1'b1, 6'b111101, 5'b00111, 8'hFD, 64'h1234);
    cyc(1);
    idle_in();
    chk("t1_count", fifo_count, 1);
    chk("t1_valid_n1", tx.tx_valid, 0);
    cyc(1);
    for (int i = 0; i < 11; i++) begin
      chk("t1_valid", tx.tx_valid, 1);
      chk("t1_byte", tx.tx_data, exp1[i]);
      cyc(1);
    end
    chk("t1_end_valid", tx.tx_valid, 0);
    cyc(2);
    // backpressure: ready pattern 1,0,0 repeating
    hs0 = hs_cnt;
    lb = log_q.size();
    drive(1'b1, 6'b111101, 5'b00111, 8'hFD, 64'h1234);
    cyc(1);
    idle_in();
    for (int k = 0; k < 200 && hs_cnt < hs0 + 11; k++) begin
      tx.tx_ready = (k % 3) == 0;
      cyc(1);
    end
    tx.tx_ready = 1'b1;
    cyc(4);
    chk("bp_handshakes", hs_cnt - hs0, 11);
    for (int i = 0; i < 11; i++) chk("bp_byte", log_q[lb+i], exp1[i]);
    // overflow: one record leaves for the shift register, eight fill the FIFO, two drop
    tx.tx_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 6'h3F, 5'($urandom), 8'(i), 64'h100 + 64'(i));
      cyc(1);
    end
    idle_in();
    chk("ov_count", fifo_count, 8);
    chk("ov_flag", overflow, 1);
    chk("ov_drop", drop_count, 2);
    lb = log_q.size();
    drain(300);
    chk("ov_bytes", log_q.size() - lb, 99);
    for (int j = 0; j < 9; j++) begin
      chk("ov_order_ts", log_q[lb+11*j+2], j);
      chk("ov_order_hlc", log_q[lb+11*j+10], j);
    end
    // inactive mask and disabled capture write nothing
    drive(1'b1, 6'd0, 5'h1F, 8'h55, 64'hDEAD);
    cyc(3);
    drive(1'b0, 6'h3F, 5'h1F, 8'h55, 64'hBEEF);
    cyc(3);
    idle_in();
    cyc(1);
    chk("inact_count", fifo_count, 0);
    chk("inact_valid", tx.tx_valid, 0);
    // captures landing on pop cycles: count holds at 1 while pointers wrap
    drive(1'b1, 6'(1 + $urandom_range(0, 62)), 5'($urandom), 8'($urandom), {$urandom, $urandom});
    cyc(1);
    for (int r = 0; r < 19; r++) begin
      chk("wrap_count", fifo_count, 1);
      drive(1'b1, 6'(1 + $urandom_range(0, 62)), 5'($urandom), 8'($urandom), {$urandom, $urandom});
      cyc(1);
      idle_in();
      cyc(11);
    end
    drain(300);
    // randomized traffic and ready
    for (int k = 0; k < 900; k++) begin
      tx.tx_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 7) == 0)
        drive(1'($urandom_range(0, 9) != 0), 6'($urandom), 5'($urandom), 8'($urandom), {$urandom, $urandom});
      else
        idle_in();
      cyc(1);
    end
    idle_in();
    drain(2000);
    // asynchronous reset after byte 4 of a record
    hs0 = hs_cnt;
    tx.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'h3F, 5'h15, 8'(i), 64'hA0 + 64'(i));
      cyc(1);
    end
    idle_in();
    for (int k = 0; k < 100 && hs_cnt < hs0 + 5; k++) cyc(1);
    chk("rst_wait", hs_cnt - hs0, 5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", tx.tx_valid, 0);
    chk("arst_data", tx.tx_data, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_drop", drop_count, 0);
    cyc(2);
    rst_n = 1'b1;
    hs0 = hs_cnt;
    cyc(30);
    chk("post_rst_hs", hs_cnt - hs0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
